n64_cmd_receiver: RTL and testbench

N64_CMD_RECEIVER -- requirements
Module: n64_cmd_receiver

---
 rtl/n64_cmd_receiver.sv | 165 ++++++++++++++++
 tb/tb_n64_cmd_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64_cmd_receiver.sv
// N64 joybus command receiver: decodes console bytes (MSB first) from the
// pulse-width encoded data line and flags frame completion or errors.
// Optional macro N64_RX_GLITCH_FILTER_EN adds a 3-sample glitch filter on the
// synchronized line (edges are then seen 2 clk cycles later).
module n64_cmd_receiver #(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       frame_done,
  output logic       frame_err,
  output logic [5:0] byte_cnt,
  output logic       busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] T_BIT1_MAX = CW'(2 * CLKS_PER_US);
  localparam logic [CW-1:0] T_END      = CW'(4 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] T_STUCK    = CW'(5 * CLKS_PER_US - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t         state, state_n;
  logic           sync1, sync2, s, s_prev;
  logic           fall, rise;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           byte_done;
  logic           start_frame, shift_en, bit_val, done_set, err_set;

  // Two-flop synchronizer for the asynchronous joybus line; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= data;
      sync2 <= sync1;
    end
  end

`ifdef N64_RX_GLITCH_FILTER_EN
  logic hist1, hist2, s_hold;

  // Sample history for the filter; s only follows three agreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1  <= 1'b1;
      hist2  <= 1'b1;
      s_hold <= 1'b1;
    end else begin
      hist1  <= sync2;
      hist2  <= hist1;
      s_hold <= s;
    end
  end

  assign s = (sync2 == hist1 && hist1 == hist2) ? sync2 : s_hold;
`else
  assign s = sync2;
`endif

  // Previous value of the decoded line for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_prev <= 1'b1;
    else     s_prev <= s;
  end

  assign fall = s_prev & ~s;
  assign rise = ~s_prev & s;
  assign busy = (state != IDLE);

  // State register and per-state duration counter, cleared on every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == IDLE) cnt <= '0;
      else                                   cnt <= cnt + 1'b1;
    end
  end

  // Next-state decode: measure low time per bit, time out stuck or ended lines
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    bit_val     = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n     = LOW;
          start_frame = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          shift_en = 1'b1;
          bit_val  = (cnt < T_BIT1_MAX);
          state_n  = HIGH;
        end else if (cnt == T_STUCK) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_n = LOW;
        end else if (cnt == T_END) begin
          state_n = IDLE;
          if (bit_cnt == 3'd1 && shreg[0] && byte_cnt != 6'd0) done_set = 1'b1;
          else                                                 err_set  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit shifting, byte hand-off one cycle after the 8th bit, and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_done  <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      byte_done  <= 1'b0;
      frame_done <= done_set;
      frame_err  <= err_set;
      if (start_frame) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg     <= {shreg[6:0], bit_val};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
      if (start_frame) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        rx_byte  <= shreg;
        rx_valid <= 1'b1;
        rx_first <= (byte_cnt == 6'd0);
        if (byte_cnt != 6'd63) byte_cnt <= byte_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_n64_cmd_receiver.sv
// Testbench for n64_cmd_receiver: directed joybus frames, a frame-level
// reference model scheduling expected pulses per cycle, and literal checks.
module tb_n64_cmd_receiver;

  localparam int US   = 50;
  localparam int T4   = 4 * US;
  localparam int T5   = 5 * US;
`ifdef N64_RX_GLITCH_FILTER_EN
  localparam int FILT = 2;
`else
  localparam int FILT = 0;
`endif
  // Posedges from a data change driven at a negedge until s shows it
  localparam int SLAT = 2 + FILT;
  localparam int MAXC = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_first, frame_done, frame_err, busy;
  logic [5:0] byte_cnt;

  n64_cmd_receiver #(.CLKS_PER_US(US)) dut (
    .clk(clk), .rst(rst), .data(data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_first(rx_first),
    .frame_done(frame_done), .frame_err(frame_err),
    .byte_cnt(byte_cnt), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int n_valid = 0, n_first = 0, n_done = 0, n_err = 0;

  bit         exp_valid [MAXC];
  bit         exp_first [MAXC];
  bit         exp_done  [MAXC];
  bit         exp_err   [MAXC];
  logic [7:0] exp_byte  [MAXC];

  // Frame-level model state
  int         m_bits, m_bytes, m_last_rise;
  logic [7:0] m_acc;
  bit         m_last;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic model_start();
    m_bits  = 0;
    m_bytes = 0;
    m_acc   = 8'h00;
    m_last  = 1'b0;
  endtask

  // A received bit whose rising edge on s lands at posedge r
  task automatic model_bit(input bit b, input int r);
    m_acc       = {m_acc[6:0], b};
    m_bits      = m_bits + 1;
    m_last      = b;
    m_last_rise = r;
    if (m_bits % 8 == 0) begin
      exp_valid[r + 2] = 1'b1;
      exp_byte[r + 2]  = m_acc;
      exp_first[r + 2] = (m_bytes == 0);
      if (m_bytes < 63) m_bytes = m_bytes + 1;
    end
  endtask

  // Line stayed high 4 us after the last bit: good stop bit or error
  task automatic model_end();
    if (m_bits % 8 == 1 && m_last && m_bytes >= 1) exp_done[m_last_rise + 1 + T4] = 1'b1;
    else                                            exp_err[m_last_rise + 1 + T4]  = 1'b1;
  endtask

  // One 4 us joybus bit: 1 = 1 us low, 0 = 3 us low; called at a negedge
  task automatic drive_bit(input bit b);
    int low;
    low  = b ? US : 3 * US;
    data = 1'b0;
    repeat (low) @(negedge clk);
    data = 1'b1;
    model_bit(b, cyc + SLAT);
    repeat (4 * US - low) @(negedge clk);
  endtask

  // Sends the low nbits of word, MSB first, then lets the model close the frame
  task automatic applyStimulus(input logic [31:0] word, input int nbits);
    model_start();
    for (int i = nbits - 1; i >= 0; i--) drive_bit(word[i]);
    model_end();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison of all pulse outputs against the model schedule
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_valid)   n_valid++;
    if (rx_first)   n_first++;
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    if (cyc < MAXC) begin
      checkOutput("rx_valid", rx_valid, exp_valid[cyc]);
      checkOutput("rx_first", rx_first, exp_first[cyc]);
      checkOutput("frame_done", frame_done, exp_done[cyc]);
      checkOutput("frame_err", frame_err, exp_err[cyc]);
      if (exp_valid[cyc]) checkOutput("rx_byte", rx_byte, exp_byte[cyc]);
    end
  end

  int v0, f0, d0, e0;

  task automatic snap();
    v0 = n_valid; f0 = n_first; d0 = n_done; e0 = n_err;
  endtask

  initial begin
    rst  = 1'b1;
    data = 1'b1;
    idle(3);
    checkOutput("reset rx_byte", rx_byte, 0);
    checkOutput("reset byte_cnt", byte_cnt, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    idle(5);

    // Single command byte 0x01 plus stop bit
    snap();
    applyStimulus(32'h0000_0003, 9);
    checkOutput("f1 busy during tail", busy, 1);
    idle(6 * US);
    checkOutput("f1 rx_byte", rx_byte, 8'h01);
    checkOutput("f1 byte_cnt", byte_cnt, 1);
    checkOutput("f1 valid pulses", n_valid - v0, 1);
    checkOutput("f1 first pulses", n_first - f0, 1);
    checkOutput("f1 done pulses", n_done - d0, 1);
    checkOutput("f1 busy after", busy, 0);

    // Three bytes 0x02, 0x80, 0x01 plus stop bit
    snap();
    applyStimulus({7'd0, 8'h02, 8'h80, 8'h01, 1'b1}, 25);
    idle(6 * US);
    checkOutput("f3 rx_byte", rx_byte, 8'h01);
    checkOutput("f3 byte_cnt", byte_cnt, 3);
    checkOutput("f3 valid pulses", n_valid - v0, 3);
    checkOutput("f3 first pulses", n_first - f0, 1);
    checkOutput("f3 done pulses", n_done - d0, 1);

    // Line held low 6 us: stuck-low error at 5 us
    snap();
    data = 1'b0;
    exp_err[cyc + SLAT + 1 + T5] = 1'b1;
    idle(6 * US);
    data = 1'b1;
    idle(2 * US);
    checkOutput("stuck err pulses", n_err - e0, 1);
    checkOutput("stuck valid pulses", n_valid - v0, 0);
    checkOutput("stuck busy", busy, 0);
    checkOutput("stuck byte_cnt", byte_cnt, 0);

    // Four bits then line high: malformed frame
    snap();
    applyStimulus(32'h0000_000A, 4);
    checkOutput("4bit busy", busy, 1);
    idle(6 * US);
    checkOutput("4bit err pulses", n_err - e0, 1);
    checkOutput("4bit done pulses", n_done - d0, 0);
    checkOutput("4bit busy after", busy, 0);

    // Reset in the middle of a byte, then a clean 0x00 frame
    model_start();
    drive_bit(1'b1);
    drive_bit(1'b0);
    data = 1'b0;
    idle(20);
    rst = 1'b1;
    idle(2);
    data = 1'b1;
    idle(2);
    checkOutput("midrst rx_byte", rx_byte, 0);
    checkOutput("midrst byte_cnt", byte_cnt, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst rx_valid", rx_valid, 0);
    checkOutput("midrst frame_err", frame_err, 0);
    rst = 1'b0;
    idle(2 * US);
    snap();
    applyStimulus({23'd0, 8'h00, 1'b1}, 9);
    idle(6 * US);
    checkOutput("f0 rx_byte", rx_byte, 8'h00);
    checkOutput("f0 byte_cnt", byte_cnt, 1);
    checkOutput("f0 done pulses", n_done - d0, 1);
    checkOutput("f0 valid pulses", n_valid - v0, 1);

    // 40 ns low glitch on an idle line
    snap();
    data = 1'b0;
    idle(2);
    data = 1'b1;
`ifndef N64_RX_GLITCH_FILTER_EN
    model_start();
    model_bit(1'b1, cyc + SLAT);
    model_end();
`endif
    idle(6 * US);
    checkOutput("glitch busy", busy, 0);
`ifdef N64_RX_GLITCH_FILTER_EN
    checkOutput("glitch err pulses", n_err - e0, 0);
    checkOutput("glitch byte_cnt", byte_cnt, 1);
`else
    checkOutput("glitch err pulses", n_err - e0, 1);
    checkOutput("glitch byte_cnt", byte_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
